// File: rtl/fifo_rr_pkt_sched.sv
// rtl/fifo_rr_pkt_sched.sv - packet-granular round-robin scheduler for a shared FIFO output mux
// Grant is held for a whole packet, followed by an inter-packet gap, with a stall watchdog.
module fifo_rr_pkt_sched #(
  parameter int PORT_NUM   = 8,
  parameter int IFG_CYCLES = 2,
  parameter int TIMEOUT    = 1023,
  parameter int TO_W       = 10
) (
  input  logic                glb_clk,
  input  logic                glb_areset_n,
  input  logic [PORT_NUM-1:0] fifo_nempty,
  input  logic                rd_eop,
  input  logic                out_ready,
  output logic [PORT_NUM-1:0] fifo_rd_en,
  output logic [7:0]          fifo_sel_code,
  output logic                pkt_done,
  output logic                timeout_err,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  localparam logic [TO_W-1:0] TO_LAST  = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [3:0]      IFG_LAST = 4'((IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1);
  localparam logic [2:0]      LAST_RST = 3'(PORT_NUM - 1);

  state_t          state;
  logic [2:0]      grant_idx;
  logic [2:0]      last_grant;
  logic [3:0]      ifg_cnt;
  logic [TO_W-1:0] to_cnt;

  logic [7:0] req;
  logic [7:0] rd_vec;
  logic [2:0] next_idx;
  logic [2:0] cand;
  logic       found;
  logic       rd;

  // Requests padded to 8 so ports beyond PORT_NUM read as permanently empty.
  always_comb begin
    req = '0;
    req[PORT_NUM-1:0] = fifo_nempty;
  end

  // Rotating priority: scan starts one past the last port that finished a turn.
  always_comb begin
    next_idx = last_grant;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= PORT_NUM; k++) begin
      cand = 3'((int'(last_grant) + k) % PORT_NUM);
      if (!found && req[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

  assign rd         = (state == XFER) && out_ready && req[grant_idx];
  assign rd_vec     = rd ? (8'd1 << grant_idx) : 8'd0;
  assign fifo_rd_en = rd_vec[PORT_NUM-1:0];
  assign busy       = (state != IDLE);

  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      state         <= IDLE;
      grant_idx     <= '0;
      last_grant    <= LAST_RST;
      ifg_cnt       <= '0;
      to_cnt        <= '0;
      fifo_sel_code <= '0;
      pkt_done      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      pkt_done    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_idx     <= next_idx;
            fifo_sel_code <= {5'b10000, next_idx};
            to_cnt        <= '0;
            state         <= XFER;
          end
        end
        XFER: begin
          if (rd) begin
            to_cnt <= '0;
            if (rd_eop) begin
              pkt_done      <= 1'b1;
              last_grant    <= grant_idx;
              fifo_sel_code <= '0;
              ifg_cnt       <= '0;
              state         <= (IFG_CYCLES > 0) ? GAP : IDLE;
            end
          end else if ((TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
            // Stalled port forfeits its turn and skips the gap.
            timeout_err   <= 1'b1;
            last_grant    <= grant_idx;
            fifo_sel_code <= '0;
            to_cnt        <= '0;
            state         <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (ifg_cnt == IFG_LAST) begin
            ifg_cnt <= '0;
            state   <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
